booth_seq_mult: RTL and testbench



---
 rtl/booth_seq_mult.sv | 133 +++++++++++++
 tb/tb_booth_seq_mult.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: multi-cycle radix-2 Booth multiplier with a start/done
// handshake. It retires one Booth step per clock, and a run-time sgn input
// selects signed or unsigned operands. The product register holds its value
// until the next completion.
module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH+1:0]     h_q, h_d;        // high accumulator, one guard bit beyond extension
    logic [WIDTH:0]       l_q, l_d;        // low accumulator, starts as the extended multiplier
    logic                 e_q, e_d;        // Booth history bit
    logic [WIDTH:0]       bext_q, bext_d;  // extended multiplicand
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    // One Booth step, computed from the current accumulator.
    logic [WIDTH+1:0]     bext_w;
    logic [WIDTH+1:0]     h_sum;
    logic [2*WIDTH+3:0]   shifted;         // {H, L, e} after the arithmetic shift

    assign bext_w = {bext_q[WIDTH], bext_q};

    // Add or subtract the multiplicand based on the Booth pair, then shift {H,L,e} right arithmetically.
    always_comb begin
        unique case ({l_q[0], e_q})
            2'b10:   h_sum = h_q - bext_w;
            2'b01:   h_sum = h_q + bext_w;
            default: h_sum = h_q;
        endcase
        shifted = $signed({h_sum, l_q, e_q}) >>> 1;
    end

    // Next-state, datapath and registered-output logic for the control FSM.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d   = state_q;
        h_d       = h_q;
        l_d       = l_q;
        e_d       = e_q;
        bext_d    = bext_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    h_d     = '0;
                    l_d     = {sgn & a[WIDTH-1], a};
                    e_d     = 1'b0;
                    bext_d  = {sgn & b[WIDTH-1], b};
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                h_d   = shifted[2*WIDTH+3:WIDTH+2];
                l_d   = shifted[WIDTH+1:1];
                e_d   = shifted[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    product_d = shifted[2*WIDTH:1];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; an asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the accumulator is a handful of flops rather than a memory array, so resetting it is cheap and keeps the state fully defined.
            state_q   <= S_IDLE;
            h_q       <= '0;
            l_q       <= '0;
            e_q       <= 1'b0;
            bext_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from pre-edge values, whatever the statement order.
            state_q   <= state_d;
            h_q       <= h_d;
            l_q       <= l_d;
            e_q       <= e_d;
            bext_q    <= bext_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Testbench for booth_seq_mult. It instantiates the multiplier at WIDTH 4, 8
// and 16 and compares each product against plain integer multiplication of
// the operands after sign or zero extension.
module tb_booth_seq_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sgn = 1'b0;

    logic start4 = 1'b0, start8 = 1'b0, start16 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic busy4, done4, busy8, done8, busy16, done16;
    logic [7:0]  prod4;
    logic [15:0] prod8;
    logic [31:0] prod16;

    int total = 0;
    int bad = 0;
    longint last_exp [0:32];

    booth_seq_mult #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sgn(sgn), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(prod4));
    booth_seq_mult #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sgn(sgn), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(prod8));
    booth_seq_mult #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sgn(sgn), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .product(prod16));

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: extend each operand to an integer per mode, multiply, keep 2*w bits.
    function automatic longint ref_mult(input int w, input bit s, input longint x, input longint y);
        longint m, xv, yv;
        m  = (longint'(1) << w) - 1;
        xv = x & m;
        yv = y & m;
        if (s && xv[w-1]) xv = xv - (longint'(1) << w);
        if (s && yv[w-1]) yv = yv - (longint'(1) << w);
        return (xv * yv) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            4:       return busy4;
            8:       return busy8;
            default: return busy16;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            4:       return done4;
            8:       return done8;
            default: return done16;
        endcase
    endfunction

    function automatic logic [63:0] get_prod(input int w);
        case (w)
            4:       return 64'(prod4);
            8:       return 64'(prod8);
            default: return 64'(prod16);
        endcase
    endfunction

    task automatic drive(input int w, input logic st, input longint x, input longint y);
        case (w)
            4:       begin start4  = st; a4  = x[3:0];  b4  = y[3:0];  end
            8:       begin start8  = st; a8  = x[7:0];  b8  = y[7:0];  end
            default: begin start16 = st; a16 = x[15:0]; b16 = y[15:0]; end
        endcase
    endtask

    // One complete transaction: accept, scramble inputs while busy, wait for done, check.
    task automatic mult(input int w, input bit s, input longint x, input longint y, input string tag);
        longint exp;
        int n;
        exp = ref_mult(w, s, x, y);
        sgn = s;
        drive(w, 1'b1, x, y);
        @(posedge clk); #1;
        check({tag, "_busy_at_accept"}, 64'(get_busy(w)), 64'd1);
        check({tag, "_product_hold"}, get_prod(w), 64'(last_exp[w]));
        drive(w, 1'b0, longint'($urandom), longint'($urandom));
        n = 0;
        while (get_done(w) !== 1'b1 && n < 3 * w + 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(w + 1));
        check({tag, "_product"}, get_prod(w), 64'(exp));
        check({tag, "_busy_at_done"}, 64'(get_busy(w)), 64'd0);
        @(posedge clk); #1;
        check({tag, "_done_drop"}, 64'(get_done(w)), 64'd0);
        last_exp[w] = exp;
    endtask

    initial begin
        longint opa [0:3];
        longint opb [0:3];
        int n;
        int n_done;

        foreach (last_exp[i]) last_exp[i] = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        foreach (opa[i]) begin opa[i] = 0; opb[i] = 0; end
        check("rst_busy4", 64'(busy4), 64'd0);
        check("rst_done4", 64'(done4), 64'd0);
        check("rst_prod4", 64'(prod4), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_prod8", 64'(prod8), 64'd0);
        check("rst_busy16", 64'(busy16), 64'd0);
        check("rst_prod16", 64'(prod16), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases.
        mult(4, 1'b1, -8, -8, "w4_s_m8_m8");
        mult(4, 1'b1, -8, 7, "w4_s_m8_7");
        mult(4, 1'b0, 15, 15, "w4_u_15_15");
        mult(4, 1'b0, 0, 9, "w4_u_0_9");
        mult(8, 1'b1, -128, -128, "w8_s_m128_m128");
        mult(8, 1'b1, 127, -1, "w8_s_127_m1");
        mult(8, 1'b0, 255, 255, "w8_u_255_255");
        mult(16, 1'b1, -32768, -32768, "w16_s_min_min");
        mult(16, 1'b0, 65535, 65535, "w16_u_max_max");

        // Back-to-back at WIDTH=8: start held high, operands garbage while busy.
        for (int k = 0; k < 4; k++) begin
            opa[k] = longint'($urandom_range(0, 255));
            opb[k] = longint'($urandom_range(0, 255));
        end
        opa[0] = -128;
        opb[0] = 127;
        sgn = 1'b1;
        drive(8, 1'b1, opa[0], opb[0]);
        @(posedge clk); #1;
        check("b2b_busy_first", 64'(busy8), 64'd1);
        for (int k = 0; k < 4; k++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
                check("b2b_no_gap", 64'(busy8 ^ done8), 64'd1);
            end while (done8 !== 1'b1 && n < 20);
            check("b2b_interval", 64'(n), 64'd9);
            check("b2b_product", 64'(prod8), 64'(ref_mult(8, 1'b1, opa[k], opb[k])));
            if (k < 3) drive(8, 1'b1, opa[k + 1], opb[k + 1]);
            else       drive(8, 1'b0, 0, 0);
            @(posedge clk); #1;
            check("b2b_busy_after", 64'(busy8), (k < 3) ? 64'd1 : 64'd0);
            check("b2b_done_after", 64'(done8), 64'd0);
        end
        last_exp[8] = ref_mult(8, 1'b1, opa[3], opb[3]);

        // Reset in the middle of a run.
        sgn = 1'b1;
        drive(8, 1'b1, 5, -3);
        @(posedge clk); #1;
        drive(8, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy8), 64'd0);
        check("midrst_done", 64'(done8), 64'd0);
        check("midrst_prod", 64'(prod8), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_done = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) n_done++;
        end
        check("midrst_no_done", 64'(n_done), 64'd0);
        foreach (last_exp[i]) last_exp[i] = 0;

        // Exhaustive sweep at WIDTH=4 in both modes.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++)
                    mult(4, s[0], longint'(i), longint'(j), "w4_sweep");

        // Random operands at WIDTH=8 and WIDTH=16.
        for (int t = 0; t < 300; t++)
            mult(8, 1'($urandom), longint'($urandom_range(0, 255)),
                 longint'($urandom_range(0, 255)), "w8_rand");
        for (int t = 0; t < 2000; t++)
            mult(16, 1'($urandom), longint'($urandom_range(0, 65535)),
                 longint'($urandom_range(0, 65535)), "w16_rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
